// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Covers the opcode map, the history entry layout and the stall FSM states.
package forwarding_hazard_unit_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic                  wr;
      logic                  load;
   } hist_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   function automatic hist_entry_t nop_entry();
      hist_entry_t e;
      e.dest = {REG_ADDR_W{1'b0}};
      e.wr   = 1'b0;
      e.load = 1'b0;
      return e;
   endfunction

   // True when the history entry writes the given register.
   function automatic logic hist_hit(hist_entry_t e, logic [REG_ADDR_W-1:0] r);
      return e.wr & (e.dest == r);
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_instr_reg_decode.sv
// Combinational register-usage decode: which sources an instruction reads,
// and which destination (if any) it writes. Writes to $0 are dropped.
module instr_reg_decode
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic [WIDTH-1:0]  instr,
   output logic [ADDR_W-1:0] rs,
   output logic [ADDR_W-1:0] rt,
   output logic              reads_rs,
   output logic              reads_rt,
   output logic [ADDR_W-1:0] dest,
   output logic              wr,
   output logic              load
);

   logic [5:0]        op_s;
   logic [5:0]        funct_s;
   logic [ADDR_W-1:0] rd_s;
   logic [ADDR_W-1:0] dest_raw_s;
   logic              wr_raw_s;
   logic              load_raw_s;
   logic              unused_s;

   assign op_s     = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd_s     = instr[15:11];
   assign funct_s  = instr[5:0];
   assign unused_s = ^instr[10:6];

   // Opcode class -> source reads and raw destination.
   always_comb begin
      reads_rs   = 1'b0;
      reads_rt   = 1'b0;
      dest_raw_s = {ADDR_W{1'b0}};
      wr_raw_s   = 1'b0;
      load_raw_s = 1'b0;
      case (op_s)
         OP_RTYPE: begin
            if (funct_s == FUNCT_JR) begin
               reads_rs = 1'b1;
            end else begin
               reads_rs   = 1'b1;
               reads_rt   = 1'b1;
               dest_raw_s = rd_s;
               wr_raw_s   = 1'b1;
            end
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
            reads_rs   = 1'b1;
            dest_raw_s = rt;
            wr_raw_s   = 1'b1;
         end
         OP_LW: begin
            reads_rs   = 1'b1;
            dest_raw_s = rt;
            wr_raw_s   = 1'b1;
            load_raw_s = 1'b1;
         end
         OP_SW, OP_BEQ, OP_BNE: begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
         end
         OP_J: begin
            reads_rs = 1'b0;
         end
         default: begin
            reads_rs = 1'b0;
         end
      endcase
   end

   assign dest = dest_raw_s;
   assign wr   = wr_raw_s & (dest_raw_s != {ADDR_W{1'b0}});
   assign load = load_raw_s & wr;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding-select and load-use stall generator for the fetched instruction,
// tracking the last two issued instructions in a private history.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Instructions,
   input  logic             flush,
   output logic             ex_forward_a,
   output logic             ex_forward_b,
   output logic             mem_forward_a,
   output logic             mem_forward_b,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   logic [ADDR_W-1:0] rs_s;
   logic [ADDR_W-1:0] rt_s;
   logic [ADDR_W-1:0] dest_s;
   logic              reads_rs_s;
   logic              reads_rt_s;
   logic              wr_s;
   logic              load_s;

   state_e            state_q, state_d;
   hist_entry_t       h1_q, h1_d;
   hist_entry_t       h2_q, h2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   hist_entry_t       cur_s;
   logic              stall_s;
   logic              sel_en_s;

   instr_reg_decode #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_decode (
      .instr    (Instructions),
      .rs       (rs_s),
      .rt       (rt_s),
      .reads_rs (reads_rs_s),
      .reads_rt (reads_rt_s),
      .dest     (dest_s),
      .wr       (wr_s),
      .load     (load_s)
   );

   // Hazard detection, forward selects and next-state for history/FSM/counter.
   always_comb begin
      cur_s.dest = dest_s;
      cur_s.wr   = wr_s;
      cur_s.load = load_s;

      stall_s = ~rst & (state_q == RUN) & ~flush & h1_q.load &
                ((reads_rs_s & hist_hit(h1_q, rs_s)) |
                 (reads_rt_s & hist_hit(h1_q, rt_s)));
      sel_en_s = ~rst & ~stall_s & ~flush;

      ex_forward_a  = sel_en_s & reads_rs_s & hist_hit(h1_q, rs_s) & ~h1_q.load;
      ex_forward_b  = sel_en_s & reads_rt_s & hist_hit(h1_q, rt_s) & ~h1_q.load;
      // A younger match in h1 shadows h2 even when h1 is a load.
      mem_forward_a = sel_en_s & reads_rs_s & hist_hit(h2_q, rs_s) &
                      ~ex_forward_a & ~hist_hit(h1_q, rs_s);
      mem_forward_b = sel_en_s & reads_rt_s & hist_hit(h2_q, rt_s) &
                      ~ex_forward_b & ~hist_hit(h1_q, rt_s);

      stall  = stall_s;
      bubble = ~rst & (stall_s | flush);

      h2_d = h1_q;
      if (stall_s | flush) begin
         h1_d = nop_entry();
      end else begin
         h1_d = cur_s;
      end

      case (state_q)
         RUN: begin
            if (stall_s) begin
               state_d = STALL;
            end else begin
               state_d = RUN;
            end
         end
         STALL:   state_d = RUN;
         default: state_d = RUN;
      endcase

      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // History, FSM and stall counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         h1_q    <= nop_entry();
         h2_q    <= nop_entry();
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule
